sx_serial_driver: RTL and testbench



---
 rtl/sx_serial_driver_if.sv | 42 ++++
 rtl/sx_serial_driver.sv | 148 ++++++++++++++
 tb/tb_sx_serial_driver.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sx_serial_driver_if.sv
// Purpose: bundles the host handshake, the operand bus, the serial lanes and
//          the harness read-back pins of sx_serial_driver into one interface.
// Signals:
//   start / ready          host request and driver-idle indication
//   op_a, op_b, op_c       parallel operands (FRAME_BITS wide)
//   ser_out[2:0]           serial lanes to harness input bits [2:0]
//   sel_low                byte select to harness input bit 7 (1 = bytes 0/2)
//   dut_uo, dut_uio        harness dedicated / bidirectional output pins
//   result, result_valid   assembled 32-bit result and its one-cycle strobe
// Modports:
//   master  the driver side (sx_serial_driver)
//   slave   the host / harness side (wrapper or bench)
//
// Handshake: a transaction is accepted on the rising clock edge at which
// start and ready are both high; the operands are sampled on that same edge.
// start is ignored whenever ready is low, and nothing is queued. Completion is
// signalled by a single-cycle result_valid pulse that has no back-pressure.
interface sx_serial_driver_if #(
    parameter int FRAME_BITS = 32
);
    logic                  start;
    logic                  ready;
    logic [FRAME_BITS-1:0] op_a;
    logic [FRAME_BITS-1:0] op_b;
    logic [FRAME_BITS-1:0] op_c;
    logic [2:0]            ser_out;
    logic                  sel_low;
    logic [7:0]            dut_uo;
    logic [7:0]            dut_uio;
    logic [31:0]           result;
    logic                  result_valid;

    modport master (
        input  start, op_a, op_b, op_c, dut_uo, dut_uio,
        output ready, ser_out, sel_low, result, result_valid
    );

    modport slave (
        output start, op_a, op_b, op_c, dut_uo, dut_uio,
        input  ready, ser_out, sel_low, result, result_valid
    );
endinterface

// File: rtl/sx_serial_driver.sv
// Purpose: host-side driver for the serial operand interface of the
//          size-exploration harness. Shifts three operands MSB-first onto
//          three lanes, then reads the 32-bit result back in two frames
//          (low byte-select, then high byte-select) through the 8+8 output pins.
// Ports:
//   clk      clock
//   reset    synchronous, active-high reset
//   bus      sx_serial_driver_if.master (handshake, operands, lanes, result)
//   state_o  current FSM state, for observation only
module sx_serial_driver #(
    parameter int FRAME_BITS    = 32,
    parameter int CAPTURE_DELAY = 1
) (
    input  logic               clk,
    input  logic               reset,
    sx_serial_driver_if.master bus,
    output logic [2:0]         state_o
);
    localparam int CW = $clog2(FRAME_BITS + CAPTURE_DELAY + 1);
    localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME_BITS);
    localparam logic [CW-1:0] LAST_WAIT = CW'(CAPTURE_DELAY);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHIFT_LO = 3'd1,
        WAIT_LO  = 3'd2,
        SHIFT_HI = 3'd3,
        WAIT_HI  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [2:0]            ser_q, ser_d;
    logic                  sel_low_q, sel_low_d;
    logic [31:0]           result_q, result_d;
    logic                  valid_q, valid_d;

    // Operands are held in rotate registers: after FRAME_BITS rotations they
    // are back to their original value, so the second frame re-shifts the
    // full operand without a separate reload copy.
    function automatic logic [FRAME_BITS-1:0] rotl(input logic [FRAME_BITS-1:0] x);
        return {x[FRAME_BITS-2:0], x[FRAME_BITS-1]};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            ser_q     <= 3'b000;
            sel_low_q <= 1'b1;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            ser_q     <= ser_d;
            sel_low_q <= sel_low_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end

    // cnt_q holds the 1-based index of the current cycle inside the
    // shift or wait phase; it reloads to 1 on every phase change.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        ser_d     = 3'b000;
        sel_low_d = sel_low_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                sel_low_d = 1'b1;
                if (bus.start) begin
                    // First bit goes out straight from the operand bus; the
                    // latched copy is already rotated past it.
                    ser_d   = {bus.op_c[FRAME_BITS-1], bus.op_b[FRAME_BITS-1], bus.op_a[FRAME_BITS-1]};
                    a_d     = rotl(bus.op_a);
                    b_d     = rotl(bus.op_b);
                    c_d     = rotl(bus.op_c);
                    cnt_d   = CNT_ONE;
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO, SHIFT_HI: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = CNT_ONE;
                    state_d = (state_q == SHIFT_LO) ? WAIT_LO : WAIT_HI;
                end else begin
                    ser_d = {c_q[FRAME_BITS-1], b_q[FRAME_BITS-1], a_q[FRAME_BITS-1]};
                    a_d   = rotl(a_q);
                    b_d   = rotl(b_q);
                    c_d   = rotl(c_q);
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (cnt_q == LAST_WAIT) begin
                    result_d[7:0]   = bus.dut_uo;
                    result_d[23:16] = bus.dut_uio;
                    ser_d     = {c_q[FRAME_BITS-1], b_q[FRAME_BITS-1], a_q[FRAME_BITS-1]};
                    a_d       = rotl(a_q);
                    b_d       = rotl(b_q);
                    c_d       = rotl(c_q);
                    sel_low_d = 1'b0;
                    cnt_d     = CNT_ONE;
                    state_d   = SHIFT_HI;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (cnt_q == LAST_WAIT) begin
                    result_d[15:8]  = bus.dut_uo;
                    result_d[31:24] = bus.dut_uio;
                    valid_d   = 1'b1;
                    sel_low_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.ready        = (state_q == IDLE);
    assign bus.ser_out      = ser_q;
    assign bus.sel_low      = sel_low_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign state_o          = state_q;
endmodule

// File: tb/tb_sx_serial_driver.sv
// Bench for sx_serial_driver: dut0 uses CAPTURE_DELAY=1 with a combinational
// harness model, dut1 uses CAPTURE_DELAY=2 with a harness model that adds one
// output register. Both harness models loop lane 0 back as the result.
module tb_sx_serial_driver;
    localparam int FB = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        start0, start1;
    logic [31:0] op_a, op_b, op_c;
    logic [2:0]  state0, state1;

    sx_serial_driver_if #(.FRAME_BITS(FB)) bus0 ();
    sx_serial_driver_if #(.FRAME_BITS(FB)) bus1 ();

    assign bus0.start = start0;
    assign bus0.op_a  = op_a;
    assign bus0.op_b  = op_b;
    assign bus0.op_c  = op_c;
    assign bus1.start = start1;
    assign bus1.op_a  = op_a;
    assign bus1.op_b  = op_b;
    assign bus1.op_c  = op_c;

    sx_serial_driver #(.FRAME_BITS(FB), .CAPTURE_DELAY(1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .state_o(state0)
    );
    sx_serial_driver #(.FRAME_BITS(FB), .CAPTURE_DELAY(2)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .state_o(state1)
    );

    // ---------------- harness models ----------------
    logic [31:0] h0 = '0;
    logic [31:0] h1 = '0;
    logic [7:0]  uo1_q = '0;
    logic [7:0]  uio1_q = '0;

    always @(posedge clk) begin
        h0 <= {h0[30:0], bus0.ser_out[0]};
        h1 <= {h1[30:0], bus1.ser_out[0]};
        uo1_q  <= bus1.sel_low ? h1[7:0]   : h1[15:8];
        uio1_q <= bus1.sel_low ? h1[23:16] : h1[31:24];
    end

    assign bus0.dut_uo  = bus0.sel_low ? h0[7:0]   : h0[15:8];
    assign bus0.dut_uio = bus0.sel_low ? h0[23:16] : h0[31:24];
    assign bus1.dut_uo  = uo1_q;
    assign bus1.dut_uio = uio1_q;

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_noexp"}, obs, ~obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {sel_low, ser_out[2:0]} of a CAPTURE_DELAY=1 driver in cycle cyc
    // after acceptance (cycle 0 = acceptance cycle).
    function automatic logic [3:0] exp_lanes(input logic [31:0] a, b, c, input int cyc);
        int       k;
        logic     sel;
        logic [2:0] s;
        sel = !(cyc >= 34 && cyc <= 66);
        s   = 3'b000;
        k   = 0;
        if (cyc >= 1 && cyc <= 32)
            k = cyc;
        else if (cyc >= 34 && cyc <= 65)
            k = cyc - 33;
        if (k != 0)
            s = {c[32-k], b[32-k], a[32-k]};
        return {sel, s};
    endfunction

    // Starts a transaction (accepted at the end of the current cycle) and
    // checks it cycle by cycle. Returns while in the cycle where the last
    // result_valid is expected. pulse_cyc / hold_cyc / abort_cyc = 0 disable.
    task automatic run_txn(input logic [31:0] a, b, c, input bit lanes, input bit with1,
                           input int pulse_cyc, input int hold_cyc,
                           input logic [31:0] next_a, input int abort_cyc);
        int last;
        last = with1 ? 69 : 67;
        if (abort_cyc == 0) exp_q.push_back(a);
        if (with1) exp_q.push_back(a);
        op_a   = a;
        op_b   = b;
        op_c   = c;
        start0 = 1'b1;
        start1 = with1;
        step();
        start0 = 1'b0;
        start1 = 1'b0;
        op_a   = ~a;
        op_b   = ~b;
        op_c   = ~c;
        for (int cyc = 1; cyc <= last; cyc++) begin
            if (cyc == 1)
                check("busy_ready", 32'(bus0.ready), 32'd0);
            if (abort_cyc != 0 && cyc == abort_cyc + 1) begin
                check("abort_ready", 32'(bus0.ready), 32'd1);
                check("abort_result", bus0.result, 32'd0);
                check("abort_lanes", 32'({bus0.sel_low, bus0.ser_out}), 32'h8);
                reset = 1'b0;
            end
            if (lanes)
                check($sformatf("lanes_c%0d", cyc), 32'({bus0.sel_low, bus0.ser_out}),
                      32'(exp_lanes(a, b, c, cyc)));
            check($sformatf("valid0_c%0d", cyc), 32'(bus0.result_valid),
                  32'(cyc == 67 && abort_cyc == 0));
            if (cyc == 67 && abort_cyc == 0) begin
                check_result("result0", bus0.result);
                check("ready_at_done", 32'(bus0.ready), 32'd1);
            end
            if (with1) begin
                check($sformatf("valid1_c%0d", cyc), 32'(bus1.result_valid), 32'(cyc == 69));
                if (cyc == 69) check_result("result1", bus1.result);
            end
            // inputs sampled at the end of this cycle
            start0 = (cyc == pulse_cyc) || (hold_cyc != 0 && cyc >= hold_cyc && cyc <= 67);
            if (hold_cyc != 0 && cyc >= hold_cyc) op_a = next_a;
            if (abort_cyc != 0 && cyc == abort_cyc) reset = 1'b1;
            if (cyc < last) step();
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        op_a   = '0;
        op_b   = '0;
        op_c   = '0;
        repeat (3) step();
        check("rst_ser0",   32'(bus0.ser_out), 32'd0);
        check("rst_sel0",   32'(bus0.sel_low), 32'd1);
        check("rst_res0",   bus0.result, 32'd0);
        check("rst_vld0",   32'(bus0.result_valid), 32'd0);
        check("rst_rdy0",   32'(bus0.ready), 32'd1);
        check("rst_state1", 32'(state1), 32'd0);
        check("rst_sel1",   32'(bus1.sel_low), 32'd1);

        // start during reset must not leave IDLE
        start0 = 1'b1;
        start1 = 1'b1;
        op_a   = 32'hFFFF_FFFF;
        step();
        check("rst_start_state0", 32'(state0), 32'd0);
        check("rst_start_rdy0",   32'(bus0.ready), 32'd1);
        check("rst_start_ser0",   32'(bus0.ser_out), 32'd0);
        check("rst_start_rdy1",   32'(bus1.ready), 32'd1);
        start0 = 1'b0;
        start1 = 1'b0;
        reset  = 1'b0;
        step();

        // lane order and ignored operand changes
        run_txn(32'h8000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, 0, '0, 0);
        // loopback on both capture delays, back-to-back on dut0
        run_txn(32'hDEAD_BEEF, 32'h3C3C_0F0F, 32'h0123_4567, 1'b1, 1'b1, 0, 0, '0, 0);
        // start pulse while busy, then start held across completion
        run_txn(32'h0BAD_F00D, 32'h5555_AAAA, 32'h0F0F_F0F0, 1'b0, 1'b0, 10, 60, 32'h1234_5678, 0);
        run_txn(32'h1234_5678, 32'h0000_FFFF, 32'hFFFF_0000, 1'b0, 1'b0, 0, 0, '0, 0);
        // reset in cycle 40 aborts, then a clean transaction
        run_txn(32'hCAFE_BABE, 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0, 0, 0, '0, 40);
        run_txn(32'hA5A5_5A5A, 32'h9696_6969, 32'h7E7E_8181, 1'b1, 1'b0, 0, 0, '0, 0);

        step();
        check("idle_valid0", 32'(bus0.result_valid), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
